axis_frame_length_enforcer: RTL

//  Single-clock AXI-Stream frame policer placed directly upstream of axis_async_fifo_wrapper (FRAME_FIFO=1).

---
 rtl/axis_frame_length_enforcer_if.sv | 32 +++
 rtl/axis_frame_length_enforcer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/axis_frame_length_enforcer_if.sv
// AXI-Stream bundle shared by the frame length enforcer and its neighbours.
// Widths are interface parameters so both ends of a link always agree.
interface AXIS_IF #(
    parameter int DATA_WIDTH     = 8,
    parameter int KEEP_WIDTH     = (DATA_WIDTH + 7) / 8,
    parameter int ID_WIDTH       = 1,
    parameter int DEST_WIDTH     = 1,
    parameter int USER_WIDTH     = 1,
    parameter int TWAKEUP_ENABLE = 0
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic [KEEP_WIDTH-1:0] tstrb;
    logic                  tlast;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tvalid;
    logic                  tready;
    logic                  twakeup;

    modport Master (
        output tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid, twakeup,
        input  tready
    );

    // Wakeup is never consumed by the enforcer, so the sink view omits it.
    modport Slave (
        input  tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid,
        output tready
    );
endinterface

// File: rtl/axis_frame_length_enforcer.sv
// AXI-Stream frame policer: cuts frames at MAX_BEATS and flags runts shorter
// than MIN_BEATS through tuser[0], so a downstream frame FIFO can drop them.
// Single registered output stage, one beat per cycle.
module axis_frame_length_enforcer #(
    parameter int   MAX_BEATS            = 256,
    parameter int   MIN_BEATS            = 1,
    parameter logic USER_BAD_FRAME_VALUE = 1'b1,
    parameter int   STATUS_CNT_WIDTH     = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    AXIS_IF.Slave                       in_axis_if,
    AXIS_IF.Master                      out_axis_if,
    output logic                        status_truncated,
    output logic                        status_runt,
    output logic                        status_good_frame,
    output logic [STATUS_CNT_WIDTH-1:0] truncated_count,
    output logic [STATUS_CNT_WIDTH-1:0] runt_count
);
    localparam int DW  = $bits(in_axis_if.tdata);
    localparam int KW  = $bits(in_axis_if.tkeep);
    localparam int IW  = $bits(in_axis_if.tid);
    localparam int DSW = $bits(in_axis_if.tdest);
    localparam int UW  = $bits(in_axis_if.tuser);
    localparam int CW  = $clog2(MAX_BEATS + 1);

    localparam logic [CW-1:0] MAX_N = CW'(MAX_BEATS);
    localparam logic [CW-1:0] MIN_N = CW'(MIN_BEATS);

    // Configuration sanity checks at elaboration time.
    generate
        if (MAX_BEATS < 1)
            $error("MAX_BEATS must be at least 1");
        if (MIN_BEATS < 1 || MIN_BEATS > MAX_BEATS)
            $error("MIN_BEATS must lie in 1..MAX_BEATS");
        if (UW < 1)
            $error("TUSER_WIDTH must be at least 1");
        if (DW != $bits(out_axis_if.tdata) || KW != $bits(out_axis_if.tkeep) ||
            IW != $bits(out_axis_if.tid) || DSW != $bits(out_axis_if.tdest) ||
            UW != $bits(out_axis_if.tuser))
            $error("input and output stream widths must match");
        if (in_axis_if.TWAKEUP_ENABLE != 0 || out_axis_if.TWAKEUP_ENABLE != 0)
            $error("twakeup is not supported");
    endgenerate

    typedef enum logic [0:0] {PASS, DROP} state_t;

    state_t        state;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] next_n;
    logic          accept;
    logic          at_max;
    logic          is_runt;
    logic [UW-1:0] bad_user;

    // In DROP the tail is swallowed, so the output stage never back-pressures it.
    assign in_axis_if.tready = (state == DROP) | out_axis_if.tready | ~out_axis_if.tvalid;
    assign accept            = in_axis_if.tvalid & in_axis_if.tready;

    assign next_n  = beat_cnt + CW'(1);
    assign at_max  = (next_n == MAX_N);
    assign is_runt = (next_n < MIN_N);

    assign out_axis_if.twakeup = 1'b0;

    // Input tuser with only the bad-frame bit overridden.
    always_comb begin
        bad_user    = in_axis_if.tuser;
        bad_user[0] = USER_BAD_FRAME_VALUE;
    end

    // Frame policing FSM, output register, status pulses and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= PASS;
            beat_cnt            <= '0;
            out_axis_if.tvalid  <= 1'b0;
            status_truncated    <= 1'b0;
            status_runt         <= 1'b0;
            status_good_frame   <= 1'b0;
            truncated_count     <= '0;
            runt_count          <= '0;
        end else begin
            status_truncated  <= 1'b0;
            status_runt       <= 1'b0;
            status_good_frame <= 1'b0;

            if (out_axis_if.tvalid && out_axis_if.tready)
                out_axis_if.tvalid <= 1'b0;

            if (accept) begin
                case (state)
                    PASS: begin
                        // Output register is free or draining this cycle.
                        out_axis_if.tvalid <= 1'b1;
                        out_axis_if.tdata  <= in_axis_if.tdata;
                        out_axis_if.tkeep  <= in_axis_if.tkeep;
                        out_axis_if.tstrb  <= in_axis_if.tstrb;
                        out_axis_if.tid    <= in_axis_if.tid;
                        out_axis_if.tdest  <= in_axis_if.tdest;
                        out_axis_if.tlast  <= in_axis_if.tlast;
                        out_axis_if.tuser  <= in_axis_if.tuser;

                        if (at_max && !in_axis_if.tlast) begin
                            // Oversize: close the frame here, mark it bad, eat the rest.
                            out_axis_if.tlast <= 1'b1;
                            out_axis_if.tuser <= bad_user;
                            status_truncated  <= 1'b1;
                            if (~&truncated_count)
                                truncated_count <= truncated_count + STATUS_CNT_WIDTH'(1);
                            beat_cnt <= '0;
                            state    <= DROP;
                        end else if (in_axis_if.tlast && is_runt) begin
                            out_axis_if.tuser <= bad_user;
                            status_runt       <= 1'b1;
                            if (~&runt_count)
                                runt_count <= runt_count + STATUS_CNT_WIDTH'(1);
                            beat_cnt <= '0;
                        end else if (in_axis_if.tlast) begin
                            status_good_frame <= 1'b1;
                            beat_cnt          <= '0;
                        end else begin
                            beat_cnt <= next_n;
                        end
                    end
                    DROP: begin
                        if (in_axis_if.tlast)
                            state <= PASS;
                    end
                    default: state <= PASS;
                endcase
            end
        end
    end
endmodule
